// File: rtl/local_ni.sv
// PE-side network interface for a router local port: TX inject FIFO with stall/gap FSM, RX absorb FIFO.
// Optional saturating flit statistics are built when NI_STATS_EN is defined.
module local_ni #(
    parameter int DATASIZE = 30,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4,
    parameter int INJ_GAP  = 0,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATASIZE-1:0] pe_tx_data,
    input  logic                pe_tx_valid,
    output logic                pe_tx_ready,
    output logic [DATASIZE-1:0] ni_data_out,
    output logic                ni_valid_out,
    input  logic                router_full_in,
    input  logic [DATASIZE-1:0] router_data_in,
    input  logic                router_valid_in,
    output logic [DATASIZE-1:0] pe_rx_data,
    output logic                pe_rx_valid,
    input  logic                pe_rx_ready,
    input  logic                ovf_clr,
    output logic                rx_overflow,
    output logic [CNT_W-1:0]    tx_flit_cnt,
    output logic [CNT_W-1:0]    rx_flit_cnt,
    output logic [CNT_W-1:0]    rx_drop_cnt
);
    localparam int TAW   = $clog2(TX_DEPTH);
    localparam int RAW   = $clog2(RX_DEPTH);
    localparam int GAP_W = (INJ_GAP > 0) ? $clog2(INJ_GAP + 1) : 1;

    typedef enum logic [1:0] {IDLE, SEND, STALL} state_e;

    state_e state_q, state_d;

    logic [DATASIZE-1:0] tx_mem [TX_DEPTH];
    logic [DATASIZE-1:0] rx_mem [RX_DEPTH];
    logic [TAW:0]        tx_wr_q, tx_rd_q;
    logic [RAW:0]        rx_wr_q, rx_rd_q;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [DATASIZE-1:0] data_q;
    logic                ovf_q;

    logic tx_full, tx_empty, tx_push, launch;
    logic rx_full, rx_push, rx_pop, rx_drop;

    assign tx_empty = (tx_wr_q == tx_rd_q);
    assign tx_full  = (tx_wr_q[TAW] != tx_rd_q[TAW]) &&
                      (tx_wr_q[TAW-1:0] == tx_rd_q[TAW-1:0]);
    assign pe_tx_ready = !rst && !tx_full;
    assign tx_push  = pe_tx_valid && pe_tx_ready;
    assign launch   = !tx_empty && (gap_q == '0) && !router_full_in;

    assign rx_full  = (rx_wr_q[RAW] != rx_rd_q[RAW]) &&
                      (rx_wr_q[RAW-1:0] == rx_rd_q[RAW-1:0]);
    assign pe_rx_valid = (rx_wr_q != rx_rd_q);
    assign pe_rx_data  = rx_mem[rx_rd_q[RAW-1:0]];
    assign rx_pop   = pe_rx_valid && pe_rx_ready;
    // a pop at the same edge frees the slot, so a full FIFO still accepts
    assign rx_push  = router_valid_in && (!rx_full || rx_pop);
    assign rx_drop  = router_valid_in && rx_full && !rx_pop;

    always_comb begin
        gap_d = gap_q;
        if (launch)
            gap_d = GAP_W'(INJ_GAP);
        else if (gap_q != '0)
            gap_d = gap_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, SEND: begin
                if (launch)
                    state_d = SEND;
                else if (router_full_in && !tx_empty)
                    state_d = STALL;
                else
                    state_d = IDLE;
            end
            STALL: begin
                if (launch)
                    state_d = SEND;
                else if (!router_full_in)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ni_valid_out = (state_q == SEND);
        ni_data_out  = data_q;
        rx_overflow  = ovf_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr_q <= '0;
            tx_rd_q <= '0;
            rx_wr_q <= '0;
            rx_rd_q <= '0;
            gap_q   <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            gap_q <= gap_d;
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (launch) begin
                tx_rd_q <= tx_rd_q + 1'b1;
                data_q  <= tx_mem[tx_rd_q[TAW-1:0]];
            end
            if (rx_push) rx_wr_q <= rx_wr_q + 1'b1;
            if (rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
            if (rx_drop)
                ovf_q <= 1'b1;
            else if (ovf_clr)
                ovf_q <= 1'b0;
        end
    end

    // storage needs no reset: pointers alone define occupancy
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q[TAW-1:0]] <= pe_tx_data;
        if (rx_push) rx_mem[rx_wr_q[RAW-1:0]] <= router_data_in;
    end

`ifdef NI_STATS_EN
    logic [CNT_W-1:0] tx_cnt_q, rx_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt_q   <= '0;
            rx_cnt_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (launch && tx_cnt_q != '1)    tx_cnt_q   <= tx_cnt_q + 1'b1;
            if (rx_push && rx_cnt_q != '1)   rx_cnt_q   <= rx_cnt_q + 1'b1;
            if (rx_drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign tx_flit_cnt = tx_cnt_q;
    assign rx_flit_cnt = rx_cnt_q;
    assign rx_drop_cnt = drop_cnt_q;
`else
    assign tx_flit_cnt = '0;
    assign rx_flit_cnt = '0;
    assign rx_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_local_ni.sv
// Directed bench for local_ni: inject ordering, stall, gap, RX overflow and async reset.
// A second instance with INJ_GAP=2 covers injection spacing.
module tb_local_ni;
    localparam int DW = 30;
    localparam int CW = 16;
`ifdef NI_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] pe_tx_data;
    logic          pe_tx_valid, g_tx_valid;
    logic          router_full_in;
    logic [DW-1:0] router_data_in;
    logic          router_valid_in;
    logic          pe_rx_ready;
    logic          ovf_clr;

    logic          pe_tx_ready, ni_valid_out, pe_rx_valid, rx_overflow;
    logic [DW-1:0] ni_data_out, pe_rx_data;
    logic [CW-1:0] tx_flit_cnt, rx_flit_cnt, rx_drop_cnt;

    logic          g_tx_ready, g_valid, g_rx_valid, g_ovf;
    logic [DW-1:0] g_data, g_rx_data;
    logic [CW-1:0] g_txc, g_rxc, g_drc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    local_ni #(.DATASIZE(DW), .INJ_GAP(0)) dut (
        .clk(clk), .rst(rst),
        .pe_tx_data(pe_tx_data), .pe_tx_valid(pe_tx_valid),
        .pe_tx_ready(pe_tx_ready),
        .ni_data_out(ni_data_out), .ni_valid_out(ni_valid_out),
        .router_full_in(router_full_in),
        .router_data_in(router_data_in), .router_valid_in(router_valid_in),
        .pe_rx_data(pe_rx_data), .pe_rx_valid(pe_rx_valid),
        .pe_rx_ready(pe_rx_ready),
        .ovf_clr(ovf_clr), .rx_overflow(rx_overflow),
        .tx_flit_cnt(tx_flit_cnt), .rx_flit_cnt(rx_flit_cnt),
        .rx_drop_cnt(rx_drop_cnt)
    );

    local_ni #(.DATASIZE(DW), .INJ_GAP(2)) dut_gap (
        .clk(clk), .rst(rst),
        .pe_tx_data(pe_tx_data), .pe_tx_valid(g_tx_valid),
        .pe_tx_ready(g_tx_ready),
        .ni_data_out(g_data), .ni_valid_out(g_valid),
        .router_full_in(router_full_in),
        .router_data_in(router_data_in), .router_valid_in(router_valid_in),
        .pe_rx_data(g_rx_data), .pe_rx_valid(g_rx_valid),
        .pe_rx_ready(pe_rx_ready),
        .ovf_clr(ovf_clr), .rx_overflow(g_ovf),
        .tx_flit_cnt(g_txc), .rx_flit_cnt(g_rxc), .rx_drop_cnt(g_drc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        pe_tx_data = '0;
        pe_tx_valid = 1'b0;
        g_tx_valid = 1'b0;
        router_full_in = 1'b0;
        router_data_in = '0;
        router_valid_in = 1'b0;
        pe_rx_ready = 1'b0;
        ovf_clr = 1'b0;
        #3;
        chk("rst_valid", 32'(ni_valid_out), 32'd0);
        chk("rst_data", 32'(ni_data_out), 32'd0);
        chk("rst_rxv", 32'(pe_rx_valid), 32'd0);
        chk("rst_ovf", 32'(rx_overflow), 32'd0);
        chk("rst_txrdy", 32'(pe_tx_ready), 32'd0);
        chk("rst_drc", 32'(rx_drop_cnt), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("txrdy_after_rst", 32'(pe_tx_ready), 32'd1);

        // 1: back-to-back injection
        pe_tx_valid = 1'b1;
        pe_tx_data = 30'h1;
        tick();
        chk("t1_lat0", 32'(ni_valid_out), 32'd0);
        pe_tx_data = 30'h2;
        tick();
        chk("t1_v1", 32'(ni_valid_out), 32'd1);
        chk("t1_d1", 32'(ni_data_out), 32'h1);
        pe_tx_data = 30'h3;
        tick();
        chk("t1_v2", 32'(ni_valid_out), 32'd1);
        chk("t1_d2", 32'(ni_data_out), 32'h2);
        pe_tx_data = 30'h4;
        tick();
        chk("t1_v3", 32'(ni_valid_out), 32'd1);
        chk("t1_d3", 32'(ni_data_out), 32'h3);
        pe_tx_valid = 1'b0;
        tick();
        chk("t1_v4", 32'(ni_valid_out), 32'd1);
        chk("t1_d4", 32'(ni_data_out), 32'h4);
        tick();
        chk("t1_end_v", 32'(ni_valid_out), 32'd0);
        chk("t1_hold_d", 32'(ni_data_out), 32'h4);

        // 2: stall on router full
        router_full_in = 1'b1;
        pe_tx_valid = 1'b1;
        pe_tx_data = 30'hA1;
        tick();
        chk("t2_st0", 32'(ni_valid_out), 32'd0);
        pe_tx_data = 30'hA2;
        tick();
        chk("t2_st1", 32'(ni_valid_out), 32'd0);
        pe_tx_valid = 1'b0;
        tick();
        chk("t2_st2", 32'(ni_valid_out), 32'd0);
        tick();
        chk("t2_st3", 32'(ni_valid_out), 32'd0);
        router_full_in = 1'b0;
        tick();
        chk("t2_v1", 32'(ni_valid_out), 32'd1);
        chk("t2_d1", 32'(ni_data_out), 32'hA1);
        tick();
        chk("t2_v2", 32'(ni_valid_out), 32'd1);
        chk("t2_d2", 32'(ni_data_out), 32'hA2);
        tick();
        chk("t2_end", 32'(ni_valid_out), 32'd0);
        chk("t2_txcnt", 32'(tx_flit_cnt), STATS ? 32'd6 : 32'd0);

        // 3: INJ_GAP=2 spacing
        g_tx_valid = 1'b1;
        pe_tx_data = 30'h11;
        tick();
        chk("t3_c0", 32'(g_valid), 32'd0);
        pe_tx_data = 30'h22;
        tick();
        chk("t3_v1", 32'(g_valid), 32'd1);
        chk("t3_d1", 32'(g_data), 32'h11);
        pe_tx_data = 30'h33;
        tick();
        g_tx_valid = 1'b0;
        chk("t3_gap1a", 32'(g_valid), 32'd0);
        tick();
        chk("t3_gap1b", 32'(g_valid), 32'd0);
        tick();
        chk("t3_v2", 32'(g_valid), 32'd1);
        chk("t3_d2", 32'(g_data), 32'h22);
        tick();
        chk("t3_gap2a", 32'(g_valid), 32'd0);
        tick();
        chk("t3_gap2b", 32'(g_valid), 32'd0);
        tick();
        chk("t3_v3", 32'(g_valid), 32'd1);
        chk("t3_d3", 32'(g_data), 32'h33);
        tick();
        chk("t3_end", 32'(g_valid), 32'd0);

        // 4: RX overflow
        router_valid_in = 1'b1;
        router_data_in = 30'hB0;
        tick();
        chk("t4_rxv", 32'(pe_rx_valid), 32'd1);
        chk("t4_head", 32'(pe_rx_data), 32'hB0);
        router_data_in = 30'hB1;
        tick();
        router_data_in = 30'hB2;
        tick();
        router_data_in = 30'hB3;
        tick();
        chk("t4_noovf", 32'(rx_overflow), 32'd0);
        router_data_in = 30'hB4;
        tick();
        chk("t4_ovf", 32'(rx_overflow), 32'd1);
        chk("t4_drc", 32'(rx_drop_cnt), STATS ? 32'd1 : 32'd0);
        chk("t4_head2", 32'(pe_rx_data), 32'hB0);
        router_valid_in = 1'b0;
        ovf_clr = 1'b1;
        tick();
        chk("t4_clr", 32'(rx_overflow), 32'd0);
        router_valid_in = 1'b1;
        router_data_in = 30'hEE;
        tick();
        chk("t4_setwins", 32'(rx_overflow), 32'd1);
        chk("t4_drc2", 32'(rx_drop_cnt), STATS ? 32'd2 : 32'd0);
        ovf_clr = 1'b0;

        // 5: simultaneous pop/push on full RX FIFO
        pe_rx_ready = 1'b1;
        router_data_in = 30'hC0;
        tick();
        router_valid_in = 1'b0;
        chk("t5_drc", 32'(rx_drop_cnt), STATS ? 32'd2 : 32'd0);
        chk("t5_rxc", 32'(rx_flit_cnt), STATS ? 32'd5 : 32'd0);
        chk("t5_h1", 32'(pe_rx_data), 32'hB1);
        tick();
        chk("t5_h2", 32'(pe_rx_data), 32'hB2);
        tick();
        chk("t5_h3", 32'(pe_rx_data), 32'hB3);
        tick();
        chk("t5_h4", 32'(pe_rx_data), 32'hC0);
        chk("t5_v4", 32'(pe_rx_valid), 32'd1);
        tick();
        chk("t5_empty", 32'(pe_rx_valid), 32'd0);
        pe_rx_ready = 1'b0;

        // 6: asynchronous reset mid-stream
        router_full_in = 1'b1;
        pe_tx_valid = 1'b1;
        router_valid_in = 1'b1;
        pe_tx_data = 30'hD1;
        router_data_in = 30'hE1;
        tick();
        pe_tx_data = 30'hD2;
        router_data_in = 30'hE2;
        tick();
        pe_tx_data = 30'hD3;
        router_data_in = 30'hE3;
        tick();
        router_valid_in = 1'b0;
        pe_tx_data = 30'hD4;
        tick();
        pe_tx_valid = 1'b0;
        chk("t6_txfull", 32'(pe_tx_ready), 32'd0);
        router_full_in = 1'b0;
        tick();
        chk("t6_v", 32'(ni_valid_out), 32'd1);
        chk("t6_d", 32'(ni_data_out), 32'hD1);
        chk("t6_rxv", 32'(pe_rx_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_v", 32'(ni_valid_out), 32'd0);
        chk("t6_async_d", 32'(ni_data_out), 32'd0);
        chk("t6_async_rxv", 32'(pe_rx_valid), 32'd0);
        chk("t6_async_ovf", 32'(rx_overflow), 32'd0);
        chk("t6_async_txc", 32'(tx_flit_cnt), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_stale_v", 32'(ni_valid_out), 32'd0);
            chk("t6_stale_rx", 32'(pe_rx_valid), 32'd0);
        end
        chk("t6_txrdy", 32'(pe_tx_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
